// File: rtl/memory_accessor.sv
// Memory-access pipeline stage: drives the data-memory request/ack port,
// builds byte enables and store lanes, and extends load data for writeback.
module memory_accessor #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_in,
    input  logic [31:0] alu_result_in,
    input  logic        mem_to_reg_in,
    input  logic [1:0]  bytes_in,
    input  logic [31:0] wdata_in,
    input  logic        we_in,
    input  logic        re_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    input  logic        unsigned_flag_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] reg_wdata_out,
    output logic [4:0]  rd_out,
    output logic        reg_we_out,
    output logic        misaligned_out,
    output logic        bus_error_out,
    output logic        run_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  timer;
    logic [7:0]  timer_next;

    logic [1:0]  acc_off;
    logic        acc_byte;
    logic        acc_half;
    logic        acc_load;
    logic        acc_uns;
    logic        acc_rwe;
    logic [4:0]  acc_rd;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_mem;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] load_val;

    // mem_to_reg is implied by re_in here; kept on the port for pipeline symmetry
    logic        unused_ok;
    assign unused_ok = mem_to_reg_in;

    assign is_mem     = we_in | re_in;
    assign is_byte    = (bytes_in == 2'd0);
    assign is_half    = (bytes_in == 2'd1);
    assign is_word    = bytes_in[1];
    assign misaligned = (is_half & alu_result_in[0])
                      | (is_word & (|alu_result_in[1:0]));

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata_in;
        unique case (1'b1)
            is_byte: begin
                be_next    = 4'b0001 << alu_result_in[1:0];
                wdata_next = {4{wdata_in[7:0]}};
            end
            is_half: begin
                be_next    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata_in[15:0]}};
            end
            is_word: begin
                be_next    = 4'b1111;
                wdata_next = wdata_in;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by size
    assign lane = dmem_rdata >> {acc_off, 3'b000};

    always_comb begin
        load_val = dmem_rdata;
        if (acc_byte) begin
            load_val = {{24{~acc_uns & lane[7]}}, lane[7:0]};
        end else if (acc_half) begin
            load_val = {{16{~acc_uns & lane[15]}}, lane[15:0]};
        end
    end

    assign timer_next = timer - 8'd1;
    assign stall_out  = (state == ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= 8'd0;
            acc_off        <= 2'd0;
            acc_byte       <= 1'b0;
            acc_half       <= 1'b0;
            acc_load       <= 1'b0;
            acc_uns        <= 1'b0;
            acc_rwe        <= 1'b0;
            acc_rd         <= 5'd0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_be        <= 4'd0;
            dmem_wdata     <= 32'd0;
            reg_wdata_out  <= 32'd0;
            rd_out         <= 5'd0;
            reg_we_out     <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            run_out        <= 1'b0;
        end else begin
            reg_we_out     <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            run_out        <= run_in;
            unique case (state)
                IDLE: begin
                    if (run_in && !is_mem) begin
                        reg_wdata_out <= alu_result_in;
                        rd_out        <= rd_in;
                        reg_we_out    <= reg_we_in;
                    end else if (run_in && misaligned) begin
                        misaligned_out <= 1'b1;
                    end else if (run_in) begin
                        state      <= ACCESS;
                        timer      <= 8'(TIMEOUT);
                        acc_off    <= alu_result_in[1:0];
                        acc_byte   <= is_byte;
                        acc_half   <= is_half;
                        acc_load   <= ~we_in;
                        acc_uns    <= unsigned_flag_in;
                        acc_rwe    <= reg_we_in;
                        acc_rd     <= rd_in;
                        dmem_req   <= 1'b1;
                        dmem_we    <= we_in;
                        dmem_addr  <= {alu_result_in[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        if (acc_load) begin
                            reg_wdata_out <= load_val;
                            rd_out        <= acc_rd;
                            reg_we_out    <= acc_rwe;
                        end
                    end else if (timer_next == 8'd0) begin
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        bus_error_out <= 1'b1;
                        timer         <= 8'd0;
                    end else begin
                        timer <= timer_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_accessor.sv
// Testbench for memory_accessor: fixed vectors, corner sequences and
// randomized transactions against a byte-level reference model.
module tb_memory_accessor;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_in;
    logic [31:0] alu_result_in;
    logic        mem_to_reg_in;
    logic [1:0]  bytes_in;
    logic [31:0] wdata_in;
    logic        we_in;
    logic        re_in;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        unsigned_flag_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic [31:0] reg_wdata_out;
    logic [4:0]  rd_out;
    logic        reg_we_out;
    logic        misaligned_out;
    logic        bus_error_out;
    logic        run_out;

    memory_accessor #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .run_in           (run_in),
        .alu_result_in    (alu_result_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .bytes_in         (bytes_in),
        .wdata_in         (wdata_in),
        .we_in            (we_in),
        .re_in            (re_in),
        .rd_in            (rd_in),
        .reg_we_in        (reg_we_in),
        .unsigned_flag_in (unsigned_flag_in),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .stall_out        (stall_out),
        .reg_wdata_out    (reg_wdata_out),
        .rd_out           (rd_out),
        .reg_we_out       (reg_we_out),
        .misaligned_out   (misaligned_out),
        .bus_error_out    (bus_error_out),
        .run_out          (run_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [1:0]  bytes;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rwe;
        logic        uns;
        logic [31:0] rdata;
        int          delay;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_val;
    } vec_t;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_wd = 32'd0;
    logic [4:0]  exp_rd = 5'd0;
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-addressed view of the access using plain arithmetic
    function automatic vec_t model(input vec_t v);
        int          n;
        int          off;
        logic [63:0] m64;
        logic [31:0] mask;
        logic [31:0] val;
        n   = (v.bytes == 2'd0) ? 1 : (v.bytes == 2'd1) ? 2 : 4;
        off = int'(v.alu % 32'd4);
        v.e_mis = (v.we | v.re) && (v.alu % 32'(n) != 0);
        v.e_be  = 4'(((1 << n) - 1) << off);
        if (n == 1) v.e_wdata = {24'h0, v.wdata[7:0]} * 32'h0101_0101;
        else if (n == 2) v.e_wdata = {16'h0, v.wdata[15:0]} * 32'h0001_0001;
        else v.e_wdata = v.wdata;
        m64  = (64'd1 << (8 * n)) - 64'd1;
        mask = m64[31:0];
        val  = (v.rdata >> (8 * off)) & mask;
        if (!v.uns && n < 4 && val[8*n-1]) val = val | ~mask;
        v.e_val = (v.we | v.re) ? val : v.alu;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        logic is_mem;
        logic is_st;
        is_mem = v.we | v.re;
        is_st  = v.we;
        alu_result_in    = v.alu;
        bytes_in         = v.bytes;
        we_in            = v.we;
        re_in            = v.re;
        mem_to_reg_in    = v.re & ~v.we;
        wdata_in         = v.wdata;
        rd_in            = v.rd;
        reg_we_in        = v.rwe;
        unsigned_flag_in = v.uns;
        dmem_ack         = 1'b0;
        dmem_rdata       = 32'hDEAD_BEEF;
        run_in           = 1'b1;
        step();
        run_in = 1'b0;
        chk("run_out_hi", 32'(run_out), 32'd1);
        if (!is_mem) begin
            chk("pt_we", 32'(reg_we_out), 32'(v.rwe));
            chk("pt_wdata", reg_wdata_out, v.e_val);
            chk("pt_rd", 32'(rd_out), 32'(v.rd));
            chk("pt_req", 32'(dmem_req), 32'd0);
            exp_wd = v.e_val;
            exp_rd = v.rd;
        end else if (v.e_mis) begin
            chk("mis_pulse", 32'(misaligned_out), 32'd1);
            chk("mis_req", 32'(dmem_req), 32'd0);
            chk("mis_stall", 32'(stall_out), 32'd0);
            chk("mis_we", 32'(reg_we_out), 32'd0);
        end else begin
            chk("acc_req", 32'(dmem_req), 32'd1);
            chk("acc_stall", 32'(stall_out), 32'd1);
            chk("acc_addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
            chk("acc_be", 32'(dmem_be), 32'(v.e_be));
            chk("acc_dwe", 32'(dmem_we), 32'(is_st));
            if (is_st) chk("acc_wdata", dmem_wdata, v.e_wdata);
            for (int k = 1; k <= TO; k++) begin
                if (k == v.delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
                step();
                dmem_ack   = 1'b0;
                dmem_rdata = 32'hDEAD_BEEF;
                if (k == v.delay) begin
                    chk("ack_req", 32'(dmem_req), 32'd0);
                    chk("ack_stall", 32'(stall_out), 32'd0);
                    chk("ack_err", 32'(bus_error_out), 32'd0);
                    chk("ack_we", 32'(reg_we_out),
                        is_st ? 32'd0 : 32'(v.rwe));
                    if (!is_st) begin
                        exp_wd = v.e_val;
                        exp_rd = v.rd;
                    end
                    chk("ack_wdata", reg_wdata_out, exp_wd);
                    chk("ack_rd", 32'(rd_out), 32'(exp_rd));
                    break;
                end else if (k == TO) begin
                    chk("to_err", 32'(bus_error_out), 32'd1);
                    chk("to_req", 32'(dmem_req), 32'd0);
                    chk("to_stall", 32'(stall_out), 32'd0);
                    chk("to_we", 32'(reg_we_out), 32'd0);
                end else begin
                    chk("wait_req", 32'(dmem_req), 32'd1);
                    chk("wait_stall", 32'(stall_out), 32'd1);
                    chk("wait_be", 32'(dmem_be), 32'(v.e_be));
                    chk("wait_err", 32'(bus_error_out), 32'd0);
                end
            end
        end
        step();
        chk("idle_we", 32'(reg_we_out), 32'd0);
        chk("idle_mis", 32'(misaligned_out), 32'd0);
        chk("idle_err", 32'(bus_error_out), 32'd0);
        chk("idle_run", 32'(run_out), 32'd0);
        chk("hold_wdata", reg_wdata_out, exp_wd);
        chk("hold_rd", 32'(rd_out), 32'(exp_rd));
    endtask

    initial begin
        vec_t v;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1;
        run_in = 1'b0; alu_result_in = '0; mem_to_reg_in = 1'b0;
        bytes_in = 2'd0; wdata_in = '0; we_in = 1'b0; re_in = 1'b0;
        rd_in = '0; reg_we_in = 1'b0; unsigned_flag_in = 1'b0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_wdata", reg_wdata_out, 32'd0);
        chk("rst_we", 32'(reg_we_out), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        reset = 1'b0;
        step();

        tbl[0]  = '{32'h1234, 2'd2, 0, 0, 32'h0, 5'd5, 1, 0,
                    32'h0, 0, 0, 4'h0, 32'h0, 32'h1234};
        tbl[1]  = '{32'h103, 2'd0, 0, 1, 32'h0, 5'd7, 1, 0,
                    32'h80FF_FF7F, 3, 0, 4'b1000, 32'h0, 32'hFFFF_FF80};
        tbl[2]  = '{32'h103, 2'd0, 0, 1, 32'h0, 5'd8, 1, 1,
                    32'h80FF_FF7F, 3, 0, 4'b1000, 32'h0, 32'h0000_0080};
        tbl[3]  = '{32'h102, 2'd1, 1, 0, 32'hABCD_1234, 5'd9, 1, 0,
                    32'h0, 2, 0, 4'b1100, 32'h1234_1234, 32'h0};
        tbl[4]  = '{32'h101, 2'd2, 0, 1, 32'h0, 5'd3, 1, 0,
                    32'h0, 1, 1, 4'h0, 32'h0, 32'h0};
        tbl[5]  = '{32'h200, 2'd2, 0, 1, 32'h0, 5'd4, 1, 0,
                    32'h1111_1111, TO + 1, 0, 4'b1111, 32'h0, 32'h0};
        tbl[6]  = '{32'h204, 2'd2, 0, 1, 32'h0, 5'd10, 1, 0,
                    32'hCAFE_F00D, TO, 0, 4'b1111, 32'h0, 32'hCAFE_F00D};
        tbl[7]  = '{32'h106, 2'd1, 0, 1, 32'h0, 5'd11, 1, 0,
                    32'h8001_7FFF, 1, 0, 4'b1100, 32'h0, 32'hFFFF_8001};
        tbl[8]  = '{32'h101, 2'd0, 1, 0, 32'h0000_0055, 5'd12, 0, 0,
                    32'h0, 1, 0, 4'b0010, 32'h5555_5555, 32'h0};
        tbl[9]  = '{32'h103, 2'd1, 1, 0, 32'h0, 5'd13, 1, 0,
                    32'h0, 1, 1, 4'h0, 32'h0, 32'h0};
        tbl[10] = '{32'h300, 2'd2, 1, 1, 32'h1122_3344, 5'd14, 1, 0,
                    32'h0, 2, 0, 4'b1111, 32'h1122_3344, 32'h0};
        tbl[11] = '{32'h308, 2'd3, 0, 1, 32'h0, 5'd15, 1, 1,
                    32'h0BAD_CAFE, 1, 0, 4'b1111, 32'h0, 32'h0BAD_CAFE};
        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // Reset in the middle of an outstanding access
        v = '{32'h400, 2'd2, 0, 1, 32'h0, 5'd20, 1, 0,
              32'h0, 0, 0, 4'hF, 32'h0, 32'h0};
        alu_result_in = v.alu; bytes_in = v.bytes; we_in = 1'b0;
        re_in = 1'b1; rd_in = v.rd; reg_we_in = 1'b1;
        run_in = 1'b1;
        step();
        run_in = 1'b0;
        step();
        chk("mid_req", 32'(dmem_req), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(stall_out), 32'd0);
        step();
        reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        step();
        dmem_ack = 1'b0;
        chk("post_rst_we", 32'(reg_we_out), 32'd0);
        chk("post_rst_req", 32'(dmem_req), 32'd0);
        step();
        chk("post_rst_we2", 32'(reg_we_out), 32'd0);
        chk("post_rst_wd", reg_wdata_out, 32'd0);
        exp_wd = 32'd0;
        exp_rd = 5'd0;

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            v.alu   = (i % 2 == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            v.bytes = 2'($urandom_range(0, 3));
            v.we    = (kind == 2 || kind == 3);
            v.re    = (kind == 1 || kind == 3);
            v.wdata = $urandom;
            v.rd    = 5'($urandom);
            v.rwe   = 1'($urandom);
            v.uns   = 1'($urandom);
            v.rdata = $urandom;
            v.delay = $urandom_range(1, TO + 1);
            run_txn(model(v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_accessor.md
# memory_accessor

Memory-access pipeline stage fed directly by the execute stage's registered outputs. It performs data loads and stores over a request/acknowledge data-memory port, with byte-enable generation, load lane extraction and sign or zero extension. It raises a stall back to execute while a bus access is outstanding. It presents the writeback value, destination register and write enable to the writeback stage, and the same value as the memory-stage forwarding source.

## Interface
- TIMEOUT, 16: cycles to wait for `dmem_ack` before aborting an access (range 1–255).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `run_in`  in  1  a new instruction is presented this cycle (one per cycle while high).
- `alu_result_in`  in  32  ALU result; the byte address for loads/stores.
- `mem_to_reg_in`  in  1  writeback value comes from memory (load).
- `bytes_in`  in  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
- `wdata_in`  in  32  store data, right-aligned.
- `we_in` / `re_in`  in  1 each  store / load request.
- `rd_in`  in  5  destination register.
- `reg_we_in`  in  1  register write enable.
- `unsigned_flag_in`  in  1  zero-extend loads when high; sign-extend otherwise.
- `dmem_req`  out  1  bus request; held high until ack or timeout.
- `dmem_we`  out  1  write request.
- `dmem_addr`  out  32  word-aligned address (`addr[1:0]` forced to 0).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read data; valid in the `dmem_ack` cycle.
- `dmem_ack`  in  1  access complete.
- `stall_out`  out  1  asserted high whenever state is not IDLE.
- `reg_wdata_out`  out  32  writeback value; also used as the forwarding value.
- `rd_out`  out  5  registered destination register.
- `reg_we_out`  out  1  one-cycle pulse per retired instruction.
- `misaligned_out`  out  1  one-cycle pulse: misaligned access dropped.
- `bus_error_out`  out  1  one-cycle pulse: access timed out.
- `run_out`  out  1  registered `run_in`.

## Operation
- States: IDLE, ACCESS.
- **IDLE with `run_in` high and neither `we_in` nor `re_in`:** pass-through.
  - `reg_wdata_out` ← `alu_result_in`, `rd_out` ← `rd_in`, `reg_we_out` ← `reg_we_in`.
  - Remain in IDLE.
- **IDLE with `run_in` high and `we_in` or `re_in` high:** run the alignment check.
  - Half access with `addr[0]` = 1 is misaligned.
  - Word access with `addr[1:0]` ≠ 0 is misaligned.
  - Misaligned: pulse `misaligned_out`, `reg_we_out` = 0, no bus request, remain in IDLE.
  - Aligned: capture address, size, data, `rd`, `reg_we`, `unsigned_flag` and direction; load the timeout counter with TIMEOUT; go to ACCESS.
- `we_in` and `re_in` both high: treated as store.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011` if `addr[1]` = 0, else `4'b1100`
  - word: `4'b1111`
- **Store data:** byte → `{4{wdata[7:0]}}`, half → `{2{wdata[15:0]}}`, word → `wdata`.
- **ACCESS:**
  - `dmem_req` = 1; `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` come from captured registers and are stable for the whole ACCESS period.
  - On `dmem_ack`, load: select the lane(s) per `addr[1:0]` and size, extend to 32 bits, register into `reg_wdata_out`; `reg_we_out` ← captured `reg_we`.
  - On `dmem_ack`, store: `reg_we_out` = 0.
  - After `dmem_ack` (load or store): return to IDLE.
  - Without ack: decrement the counter. When the counter reaches 0 without ack: pulse `bus_error_out`, `reg_we_out` = 0, drop `dmem_req`, return to IDLE.
- `run_in` is ignored in ACCESS. Execute must hold its outputs because `stall_out` is high.
- An ack arriving in the same cycle the counter reaches 0: the ack wins and no error is raised.

## Timing
- **Reset values:** all outputs and registers = 0, state = IDLE. Reset mid-ACCESS drops `dmem_req` asynchronously and discards the access.
- **Pass-through latency:** outputs valid one cycle after the `run_in` cycle.
- **Loads/stores:**
  - Instruction sampled at edge E0.
  - `dmem_req` and `stall_out` high from E0 to the edge at which ack is sampled (Ea ≥ E0+1).
  - `reg_*` outputs valid after Ea; `stall_out` low after Ea.
  - Minimum load latency: 2 cycles.
- **Timeout:** `bus_error_out` pulses after edge E0+TIMEOUT; `dmem_req` low from that edge.
- `reg_we_out`, `misaligned_out` and `bus_error_out` are single-cycle pulses. `reg_wdata_out` and `rd_out` hold until the next retirement.

## Test plan
- Pass-through: `alu_result_in`=0x1234, `rd_in`=5, `reg_we_in`=1 → next cycle `reg_wdata_out`=0x1234, `rd_out`=5, `reg_we_out` pulse, no `dmem_req`.
- Signed/unsigned byte load: address 0x103, `dmem_rdata`=0x80FF_FF7F, ack after 3 cycles → signed gives 0xFFFF_FF80, unsigned gives 0x0000_0080; `stall_out` high exactly while `dmem_req` is high.
- Half store: address 0x102, `wdata_in`=0xABCD_1234 → `dmem_be`=1100, `dmem_wdata`=0x1234_1234, `dmem_addr`=0x100, `dmem_we`=1, `reg_we_out`=0.
- Misaligned word load at 0x101 → `misaligned_out` pulse, no `dmem_req`, `stall_out` stays 0.
- Timeout: TIMEOUT=4, ack never comes → `bus_error_out` after 4 cycles, `dmem_req` falls; an ack arriving exactly on cycle 4 completes the access normally.
- Async reset asserted mid-ACCESS → `dmem_req`, `stall_out` low immediately; no `reg_we_out` after reset release.
